uart16750_host_ctrl: RTL and testbench
======================================

Name: uart16750_host_ctrl

Overview:
- Register-bus master for the uart_16750 core; sits directly upstream of it and replaces ad-hoc configuration logic.
- After reset, it programs the UART: divisor, line control, FIFO control and IER.
- It then services the core by polling LSR:
  - moves received bytes out on an rx valid/ready stream;
  - writes bytes taken from a tx valid/ready stream into THR.
- Runs entirely on clk_33M, the same clock as the UART core.

Parameters:
- DIVISOR, 16'h0011, baud divisor written to DLL (low byte) and DLM (high byte).
- LCR_VAL, 8'h03, final LCR value (8N1, DLAB=0).
- FCR_VAL, 8'h81, FCR value (FIFO enable, RX trigger level).
- IER_VAL, 8'h01, IER value (RX data available interrupt).

Ports:
- clk_33M  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx byte offered
- tx_ready  out  1  tx holding register empty
- rx_data  out  8  received byte
- rx_valid  out  1  rx byte held
- rx_ready  in  1  downstream accepts rx byte
- rx_overrun  out  1  one-cycle pulse when an LSR read shows OE (bit1)
- cfg_done  out  1  configuration complete, stays high until reset
- uart_cs  out  1  UART chip select
- uart_wr  out  1  UART write strobe
- uart_rd  out  1  UART read strobe
- uart_addr  out  3  UART register address
- uart_din  out  8  write data to UART
- uart_dout  in  8  read data from UART
- uart_int  in  1  UART interrupt; wakes polling immediately, otherwise unused

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk_33M.
- All outputs are registered.
- Reset values:
  - uart_cs/wr/rd = 0, uart_addr = 0, uart_din = 0;
  - tx_ready = 0, rx_valid = 0, rx_data = 0, rx_overrun = 0, cfg_done = 0.
- Bus cycle:
  - exactly one clk with uart_cs=1 and exactly one of wr/rd = 1;
  - always followed by one idle cycle with cs=wr=rd=0;
  - read data is sampled from uart_dout at the edge that ends the strobe cycle;
  - wr and rd are never high together.
- States: CFG, IDLE, LSR_RD, DECIDE, RBR_RD, THR_WR, GAP.
- CFG issues six writes in order, each followed by a gap:
  - (3, 8'h80|LCR_VAL), (0, DIVISOR[7:0]), (1, DIVISOR[15:8]), (3, LCR_VAL), (2, FCR_VAL), (1, IER_VAL);
  - a 3-bit index selects the current entry;
  - cfg_done goes high the cycle after the sixth gap, then the FSM enters IDLE.
- tx_ready is high only when cfg_done=1 and the tx holding register is empty.
- tx handshake: tx_valid & tx_ready loads the holding register and drops tx_ready next cycle.
- IDLE moves to LSR_RD when any of these is true:
  - rx_valid=0;
  - the tx holding register is full;
  - uart_int=1;
  - the free-running poll counter (16 cycles) expires.
- DECIDE acts on the captured LSR, evaluated in this order:
  - OE=1: pulse rx_overrun for one cycle.
  - DR=1 and rx_valid=0: go to RBR_RD (addr 0). Captured byte goes to rx_data; rx_valid=1 the cycle after capture.
  - Otherwise, THRE (bit5)=1 and tx holding register full: go to THR_WR (addr 0, din = held byte). Holding register empties and tx_ready rises after the gap.
  - Otherwise: return to IDLE.
- RX has priority over TX; only one data access is made per LSR poll.
- rx handshake: rx_valid & rx_ready clears rx_valid the next cycle.
- While rx_valid=1, RBR is never read; the UART FIFO supplies the backpressure.
- tx_valid while tx_ready=0 is ignored and does not need to be held stable by the RTL.
- Accepting a tx byte and starting a THR write in the same cycle is allowed; the holding register is occupied until the gap following the write.
- rstn asserted mid-access: strobes drop immediately (asynchronous). After release, the full configuration sequence reruns and held bytes are discarded.

Optional Feature:
- Macro: UART_HOST_LOOPBACK_EN.
- When defined: a seventh CFG write (4, 8'h10) sets MCR loop mode, so TX→RX self-test runs without pins. cfg_done rises two cycles later than without it.
- When undefined: six writes only; MCR is never written.

Decomposition:
- Package uart_host_pkg holds:
  - register address constants (RBR/THR/DLL=0, IER/DLM=1, FCR=2, LCR=3, MCR=4, LSR=5);
  - LSR bit indices: DR=0, OE=1, THRE=5;
  - DLAB mask 8'h80, MCR loop value 8'h10;
  - the FSM state enum.
- One sub-module is natural: uart_host_cfg_rom, a combinational index→(addr, data) table that takes the parameters and the loopback macro.

Test Plan:
- Reset release with defaults → bus writes (3,83) (0,11) (1,00) (3,03) (2,81) (1,01), each one cycle wide with one gap; cfg_done=1 on cycle 13; tx_ready=1 after that.
- tx_data=8'h41 handshaked, model LSR=8'h20 → LSR read, then one write of addr 0, din 8'h41; tx_ready back high after the gap.
- Model LSR=8'h01 with RBR=8'h20, rx_ready=0 → rx_data=8'h20, rx_valid held; no further RBR reads while held. With rx_ready=1, rx_valid clears the next cycle.
- LSR=8'h21 with a tx byte pending and rx empty → RBR read first; THR write only on a later poll.
- LSR=8'h02 → rx_overrun high for exactly one cycle; no data access.
- rstn pulsed low during THR_WR → cs/wr drop immediately; after release, the six-write sequence repeats and cfg_done=0 until it completes.

Source files
------------

// File: rtl/uart_host_pkg.sv
// ============================================================================
// uart_host_pkg : shared constants and FSM states for uart16750_host_ctrl.
// Config macro  : UART_HOST_LOOPBACK_EN adds an MCR loop-mode write to CFG.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package uart_host_pkg;

    localparam logic [2:0] c_ADDR_RBR = 3'd0;
    localparam logic [2:0] c_ADDR_THR = 3'd0;
    localparam logic [2:0] c_ADDR_DLL = 3'd0;
    localparam logic [2:0] c_ADDR_IER = 3'd1;
    localparam logic [2:0] c_ADDR_DLM = 3'd1;
    localparam logic [2:0] c_ADDR_FCR = 3'd2;
    localparam logic [2:0] c_ADDR_LCR = 3'd3;
    localparam logic [2:0] c_ADDR_MCR = 3'd4;
    localparam logic [2:0] c_ADDR_LSR = 3'd5;

    localparam int c_LSR_DR   = 0;
    localparam int c_LSR_OE   = 1;
    localparam int c_LSR_THRE = 5;

    localparam logic [7:0] c_DLAB_MASK = 8'h80;
    localparam logic [7:0] c_MCR_LOOP  = 8'h10;

`ifdef UART_HOST_LOOPBACK_EN
    localparam logic [2:0] c_CFG_COUNT = 3'd7;
`else
    localparam logic [2:0] c_CFG_COUNT = 3'd6;
`endif

    typedef enum logic [2:0] {
        ST_CFG    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LSR_RD = 3'd2,
        ST_DECIDE = 3'd3,
        ST_RBR_RD = 3'd4,
        ST_THR_WR = 3'd5,
        ST_GAP    = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_host_cfg_rom.sv
// ============================================================================
// uart_host_cfg_rom : index -> (address, data) table of the power-up writes.
// Config macro      : UART_HOST_LOOPBACK_EN appends entry 6 (MCR loop mode).
// Revision          : 1.0
// ============================================================================
`default_nettype none

module uart_host_cfg_rom
    import uart_host_pkg::*;
#(
    parameter logic [15:0] DIVISOR = 16'h0011,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter logic [7:0]  FCR_VAL = 8'h81,
    parameter logic [7:0]  IER_VAL = 8'h01
) (
    input  logic [2:0] i_idx,
    output logic [2:0] o_addr,
    output logic [7:0] o_data
);

    always_comb begin
        o_addr = 3'd0;
        o_data = 8'h00;
        case (i_idx)
            3'd0: begin o_addr = c_ADDR_LCR; o_data = c_DLAB_MASK | LCR_VAL; end
            3'd1: begin o_addr = c_ADDR_DLL; o_data = DIVISOR[7:0];          end
            3'd2: begin o_addr = c_ADDR_DLM; o_data = DIVISOR[15:8];         end
            3'd3: begin o_addr = c_ADDR_LCR; o_data = LCR_VAL;               end
            3'd4: begin o_addr = c_ADDR_FCR; o_data = FCR_VAL;               end
            3'd5: begin o_addr = c_ADDR_IER; o_data = IER_VAL;               end
`ifdef UART_HOST_LOOPBACK_EN
            3'd6: begin o_addr = c_ADDR_MCR; o_data = c_MCR_LOOP;            end
`endif
            default: begin o_addr = 3'd0; o_data = 8'h00; end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/uart16750_host_ctrl.sv
// ============================================================================
// uart16750_host_ctrl : configures a uart_16750 after reset, then polls LSR to
// move RX bytes to a valid/ready stream and TX bytes from one into THR.
// Config macro        : UART_HOST_LOOPBACK_EN (MCR loop mode during CFG).
// Revision            : 1.0
// ============================================================================
`default_nettype none

module uart16750_host_ctrl
    import uart_host_pkg::*;
#(
    parameter logic [15:0] DIVISOR = 16'h0011,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter logic [7:0]  FCR_VAL = 8'h81,
    parameter logic [7:0]  IER_VAL = 8'h01
) (
    input  logic       clk_33M,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       cfg_done,
    output logic       uart_cs,
    output logic       uart_wr,
    output logic       uart_rd,
    output logic [2:0] uart_addr,
    output logic [7:0] uart_din,
    input  logic [7:0] uart_dout,
    input  logic       uart_int
);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_poll;
    logic       r_lsr_dr, r_lsr_oe, r_lsr_thre;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic       r_gap_thr;
    logic       r_cs, r_wr, r_rd;
    logic [2:0] r_addr;
    logic [7:0] r_din;
    logic       r_tx_ready, r_rx_valid, r_rx_ovr, r_cfg_done;
    logic [7:0] r_rx_data;

    logic [2:0] w_rom_addr;
    logic [7:0] w_rom_data;
    logic       w_poll_due;
    logic       w_poll_start;

    uart_host_cfg_rom #(
        .DIVISOR (DIVISOR),
        .LCR_VAL (LCR_VAL),
        .FCR_VAL (FCR_VAL),
        .IER_VAL (IER_VAL)
    ) u_cfg_rom (
        .i_idx  (r_idx),
        .o_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

    // Free-running poll timer keeps LSR sampled even while RX output is stalled.
    always_ff @(posedge clk_33M or negedge rstn) begin
        if (!rstn) r_poll <= 4'd0;
        else       r_poll <= r_poll + 4'd1;
    end

    assign w_poll_due   = &r_poll;
    assign w_poll_start = !r_rx_valid || r_hold_full || uart_int || w_poll_due;

    always_ff @(posedge clk_33M or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_CFG;
            r_idx       <= 3'd0;
            r_lsr_dr    <= 1'b0;
            r_lsr_oe    <= 1'b0;
            r_lsr_thre  <= 1'b0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_gap_thr   <= 1'b0;
            r_cs        <= 1'b0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_addr      <= 3'd0;
            r_din       <= 8'h00;
            r_tx_ready  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_ovr    <= 1'b0;
            r_cfg_done  <= 1'b0;
        end else begin
            r_rx_ovr <= 1'b0;

            if (tx_valid && r_tx_ready) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
                r_tx_ready  <= 1'b0;
            end

            if (r_rx_valid && rx_ready)
                r_rx_valid <= 1'b0;

            case (r_state)
                // Alternates strobe / gap; the index advances on each gap.
                ST_CFG: begin
                    if (r_cs) begin
                        r_cs  <= 1'b0;
                        r_wr  <= 1'b0;
                        r_idx <= r_idx + 3'd1;
                    end else if (r_idx == c_CFG_COUNT) begin
                        r_cfg_done <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cs   <= 1'b1;
                        r_wr   <= 1'b1;
                        r_addr <= w_rom_addr;
                        r_din  <= w_rom_data;
                    end
                end
                ST_IDLE: begin
                    if (w_poll_start) begin
                        r_cs    <= 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= c_ADDR_LSR;
                        r_state <= ST_LSR_RD;
                    end
                end
                ST_LSR_RD: begin
                    r_lsr_dr   <= uart_dout[c_LSR_DR];
                    r_lsr_oe   <= uart_dout[c_LSR_OE];
                    r_lsr_thre <= uart_dout[c_LSR_THRE];
                    r_cs       <= 1'b0;
                    r_rd       <= 1'b0;
                    r_state    <= ST_DECIDE;
                end
                // Bus is idle here, which doubles as the gap after the LSR read.
                ST_DECIDE: begin
                    r_rx_ovr <= r_lsr_oe;
                    if (r_lsr_dr && !r_rx_valid) begin
                        r_cs    <= 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= c_ADDR_RBR;
                        r_state <= ST_RBR_RD;
                    end else if (r_lsr_thre && r_hold_full) begin
                        r_cs    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_addr  <= c_ADDR_THR;
                        r_din   <= r_hold;
                        r_state <= ST_THR_WR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RBR_RD: begin
                    r_rx_data  <= uart_dout;
                    r_rx_valid <= 1'b1;
                    r_cs       <= 1'b0;
                    r_rd       <= 1'b0;
                    r_gap_thr  <= 1'b0;
                    r_state    <= ST_GAP;
                end
                ST_THR_WR: begin
                    r_cs      <= 1'b0;
                    r_wr      <= 1'b0;
                    r_gap_thr <= 1'b1;
                    r_state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap_thr) begin
                        r_hold_full <= 1'b0;
                        r_tx_ready  <= 1'b1;
                    end
                    r_gap_thr <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign uart_cs    = r_cs;
    assign uart_wr    = r_wr;
    assign uart_rd    = r_rd;
    assign uart_addr  = r_addr;
    assign uart_din   = r_din;
    assign tx_ready   = r_tx_ready;
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign rx_overrun = r_rx_ovr;
    assign cfg_done   = r_cfg_done;

endmodule

`default_nettype wire

// File: tb/tb_uart16750_host_ctrl.sv
// ============================================================================
// tb_uart16750_host_ctrl : randomized bench with a transaction-level model of
// the host controller and a simple UART register responder.
// Revision               : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart16750_host_ctrl;

    logic       clk_33M = 1'b0;
    logic       rstn    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       cfg_done;
    logic       uart_cs, uart_wr, uart_rd;
    logic [2:0] uart_addr;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic       uart_int = 1'b0;

    logic [7:0] m_lsr = 8'h00;
    logic [7:0] m_rbr = 8'h00;

    always #15 clk_33M = ~clk_33M;

    assign uart_dout = (uart_addr == 3'd5) ? m_lsr : m_rbr;

    uart16750_host_ctrl dut (
        .clk_33M    (clk_33M),
        .rstn       (rstn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun),
        .cfg_done   (cfg_done),
        .uart_cs    (uart_cs),
        .uart_wr    (uart_wr),
        .uart_rd    (uart_rd),
        .uart_addr  (uart_addr),
        .uart_din   (uart_din),
        .uart_dout  (uart_dout),
        .uart_int   (uart_int)
    );

`ifdef UART_HOST_LOOPBACK_EN
    localparam int N_CFG = 7;
`else
    localparam int N_CFG = 6;
`endif
    localparam int DONE_CYC = 2 * N_CFG + 1;

    // {addr, data} of the power-up writes with default parameters.
    logic [10:0] cfg_tab [0:6] = '{
        {3'd3, 8'h83}, {3'd0, 8'h11}, {3'd1, 8'h00}, {3'd3, 8'h03},
        {3'd2, 8'h81}, {3'd1, 8'h01}, {3'd4, 8'h10}
    };

    int checks = 0;
    int errors = 0;
    int phase  = 0;
    bit tmo    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    int         cyc, cfg_k, exp_next, idle_cnt;
    bit         m_cfg_done, m_tx_ready, m_hold_full, m_rx_valid, m_ovr;
    bit         thr_pend, ovr_pend, prev_cs;
    logic [7:0] m_hold, m_rx_data;

    initial begin : cmp
        bit ev_lsr, ev_rbr, ev_thr;
        logic [10:0] ent;
        forever begin
            @(negedge clk_33M);
            chk("stim_timeout", 32'(tmo), 0);
            if (!rstn) begin
                chk("rst_cs",   32'(uart_cs), 0);
                chk("rst_wr",   32'(uart_wr), 0);
                chk("rst_rd",   32'(uart_rd), 0);
                chk("rst_addr", 32'(uart_addr), 0);
                chk("rst_din",  32'(uart_din), 0);
                chk("rst_txr",  32'(tx_ready), 0);
                chk("rst_rxv",  32'(rx_valid), 0);
                chk("rst_rxd",  32'(rx_data), 0);
                chk("rst_ovr",  32'(rx_overrun), 0);
                chk("rst_done", 32'(cfg_done), 0);
                cyc = 0; cfg_k = 0; exp_next = 0; idle_cnt = 0;
                m_cfg_done = 0; m_tx_ready = 0; m_hold_full = 0; m_rx_valid = 0;
                m_ovr = 0; thr_pend = 0; ovr_pend = 0; prev_cs = 0;
                m_hold = 8'h00; m_rx_data = 8'h00;
            end else begin
                chk("cfg_done",   32'(cfg_done), 32'(m_cfg_done));
                chk("tx_ready",   32'(tx_ready), 32'(m_tx_ready));
                chk("rx_valid",   32'(rx_valid), 32'(m_rx_valid));
                chk("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
                if (m_rx_valid) chk("rx_data", 32'(rx_data), 32'(m_rx_data));
                if (phase == 3 && m_rx_valid) chk("rx_20", 32'(rx_data), 32'h20);
                chk("strobe_shape", 32'(uart_cs ? (uart_wr ^ uart_rd) : !(uart_wr | uart_rd)), 1);
                if (uart_cs) chk("strobe_gap", 32'(prev_cs), 0);

                ev_lsr = 0; ev_rbr = 0; ev_thr = 0;
                if (uart_cs) begin
                    if (cfg_k < N_CFG) begin
                        ent = cfg_tab[cfg_k];
                        chk("cfg_wr",   32'(uart_wr), 1);
                        chk("cfg_addr", 32'(uart_addr), 32'(ent[10:8]));
                        chk("cfg_din",  32'(uart_din), 32'(ent[7:0]));
                        chk("cfg_cyc",  32'(cyc), 32'(2 * cfg_k + 1));
                        cfg_k++;
                    end else if (exp_next == 1) begin
                        chk("rbr_rd", 32'({uart_rd, uart_addr}), 32'({1'b1, 3'd0}));
                        ev_rbr = 1;
                    end else if (exp_next == 2) begin
                        chk("thr_wr", 32'({uart_wr, uart_addr, uart_din}), 32'({1'b1, 3'd0, m_hold}));
                        if (phase == 2) chk("thr_41", 32'(uart_din), 32'h41);
                        ev_thr = 1;
                    end else begin
                        chk("lsr_rd", 32'({uart_rd, uart_addr}), 32'({1'b1, 3'd5}));
                        ev_lsr = 1;
                    end
                end
                if (m_cfg_done) begin
                    idle_cnt = uart_cs ? 0 : idle_cnt + 1;
                    chk("poll_alive", 32'(idle_cnt < 40), 1);
                end

                // next-cycle model state
                m_cfg_done = (cyc + 1 >= DONE_CYC);
                cyc++;
                if (m_tx_ready && tx_valid) begin
                    m_hold = tx_data;
                    m_hold_full = 1;
                end
                if (thr_pend) begin
                    m_hold_full = 0;
                    thr_pend = 0;
                end
                if (ev_thr) thr_pend = 1;
                m_tx_ready = m_cfg_done && !m_hold_full;
                if (ev_rbr) begin
                    m_rx_valid = 1;
                    m_rx_data  = m_rbr;
                end else if (m_rx_valid && rx_ready) begin
                    m_rx_valid = 0;
                end
                m_ovr = ovr_pend;
                ovr_pend = ev_lsr && m_lsr[1];
                if (ev_lsr) begin
                    if (m_lsr[0] && !m_rx_valid)       exp_next = 1;
                    else if (m_lsr[5] && m_hold_full)  exp_next = 2;
                    else                               exp_next = 0;
                end else if (ev_rbr || ev_thr) begin
                    exp_next = 0;
                end
                prev_cs = uart_cs;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) begin @(posedge clk_33M); #1; end
    endtask

    task automatic send_tx(input logic [7:0] b);
        int n = 0;
        tx_data = b;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(posedge clk_33M); #1; n++;
        end
        if (n >= 200) begin
            $display("FAIL send_tx: tx_ready %0b required 1 within 200 cycles", tx_ready);
            tmo = 1'b1;
        end
        tx_valid = 1'b1;
        @(posedge clk_33M); #1;
        tx_valid = 1'b0;
    endtask

    initial begin : stim
        int n;
        rstn = 1'b0;
        run(3);
        rstn = 1'b1;

        phase = 1;                       // configuration sequence
        run(30);

        phase = 2;                       // single TX byte
        m_lsr = 8'h20;
        send_tx(8'h41);
        run(20);

        phase = 3;                       // RX byte held under backpressure
        m_lsr = 8'h01; m_rbr = 8'h20; rx_ready = 1'b0;
        run(60);
        rx_ready = 1'b1; m_lsr = 8'h00;
        run(10);

        phase = 4;                       // RX wins over pending TX
        send_tx(8'h77);
        rx_ready = 1'b0; m_lsr = 8'h21; m_rbr = 8'h5A;
        run(40);
        rx_ready = 1'b1; m_lsr = 8'h00;
        run(10);

        phase = 5;                       // overrun pulses
        m_lsr = 8'h02;
        run(12);
        m_lsr = 8'h00;
        run(5);

        phase = 6;                       // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            m_lsr    = 8'($urandom) & 8'h23;
            m_rbr    = 8'($urandom);
            tx_data  = 8'($urandom);
            tx_valid = 1'($urandom_range(0, 1));
            rx_ready = ($urandom_range(0, 3) != 0);
            uart_int = ($urandom_range(0, 7) == 0);
            run(1);
        end
        tx_valid = 1'b0; uart_int = 1'b0; rx_ready = 1'b1;

        phase = 7;                       // reset during a THR write
        m_lsr = 8'h20;
        run(20);
        send_tx(8'h3C);
        n = 0;
        while (!(uart_cs && uart_wr && cfg_done) && n < 200) begin
            @(posedge clk_33M); #1; n++;
        end
        if (n >= 200) begin
            $display("FAIL thr_wait: no THR write within 200 cycles");
            tmo = 1'b1;
        end
        rstn = 1'b0;
        run(2);
        rstn = 1'b1;
        run(40);
        send_tx(8'hA5);
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
